// File: rtl/dm_pkg.sv
// dm_pkg: shared FSM state encoding and default widths for the data-memory bridge
package dm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_RREQ, S_RWAIT, S_RDONE} dm_state_e;
  localparam int DM_ADDR_W   = 32;
  localparam int DM_DATA_W   = 32;
  localparam int DM_WB_DEPTH = 2;
endpackage

// File: rtl/wbuf_fifo.sv
// wbuf_fifo: posted-store FIFO of {addr, data}
//   clk/rst (async, active-low), push/pop strobes with push_addr/push_data,
//   full/empty, more (two or more entries), head_* (oldest entry), next_* (entry behind head)
import dm_pkg::*;
module wbuf_fifo #(
  parameter int DEPTH = DM_WB_DEPTH,
  parameter int AW    = DM_ADDR_W,
  parameter int DW    = DM_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  output logic          full,
  output logic          empty,
  output logic          more,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [AW-1:0] next_addr,
  output logic [DW-1:0] next_data
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;
  logic [PW:0] wr_ptr, rd_ptr, count;
  logic [PW-1:0] rd_nx;
  logic [AW+DW-1:0] mem [DEPTH];
  assign count = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign more  = count > ONE;
  assign rd_nx = rd_ptr[PW-1:0] + ONE[PW-1:0];
  assign {head_addr, head_data} = mem[rd_ptr[PW-1:0]];
  assign {next_addr, next_data} = mem[rd_nx];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop) rd_ptr <= rd_ptr + ONE;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[PW-1:0]] <= {push_addr, push_data};
endmodule

// File: rtl/dm_bridge.sv
// dm_bridge: CPU data-memory port to handshaked SRAM/bus with posted stores and stalling loads
//   CPU side: DM_address/DM_in/DM_enable/DM_write in, DM_out/stall out
//   Memory side: mem_req/mem_we/mem_addr/mem_wdata out (registered), mem_gnt/mem_rvalid/mem_rdata in
//   clk rising edge, rst asynchronous active-low
import dm_pkg::*;
module dm_bridge #(
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int WB_DEPTH = DM_WB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_in,
  input  logic              DM_enable,
  input  logic              DM_write,
  output logic [DATA_W-1:0] DM_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  dm_state_e state;
  logic [DATA_W-1:0] rd_reg;
  logic load, store, full, empty, more, push, pop, drain_ok, go_read;
  logic [ADDR_W-1:0] head_addr, next_addr;
  logic [DATA_W-1:0] head_data, next_data;
  assign load     = DM_enable & ~DM_write;
  assign store    = DM_enable & DM_write;
  assign stall    = rst & ((load & (state != S_RDONE)) | (store & full));
  assign push     = store & ~stall;
  assign pop      = mem_req & mem_we & mem_gnt;
  assign drain_ok = (state == S_IDLE) | (state == S_DRAIN);
  // a read may start only once every posted store has been accepted by memory
  assign go_read  = drain_ok & empty & ~mem_req & ((state == S_DRAIN) | load);
  assign DM_out   = rd_reg;
  wbuf_fifo #(.DEPTH(WB_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_wbuf (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .push_addr(DM_address), .push_data(DM_in),
    .full(full), .empty(empty), .more(more),
    .head_addr(head_addr), .head_data(head_data),
    .next_addr(next_addr), .next_data(next_data)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= S_IDLE;
      rd_reg    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // on a write grant the entry behind the head goes out back-to-back if present
      if (mem_req && mem_gnt) begin
        mem_req <= mem_we && more;
        if (mem_we) begin
          mem_addr  <= next_addr;
          mem_wdata <= next_data;
        end
      end else if (!mem_req && drain_ok && !empty) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= head_addr;
        mem_wdata <= head_data;
      end else if (go_read) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= DM_address;
      end
      unique case (state)
        S_IDLE, S_DRAIN: state <= go_read ? S_RREQ : (load ? S_DRAIN : state);
        S_RREQ:          state <= mem_gnt ? S_RWAIT : S_RREQ;
        S_RWAIT:
          if (mem_rvalid) begin
            rd_reg <= mem_rdata;
            state  <= S_RDONE;
          end
        default:         state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dm_bridge.sv
// tb_dm_bridge: directed and randomized checks of dm_bridge against a CPU-view memory model
module tb_dm_bridge;
  typedef struct {logic we; logic [31:0] a; logic [31:0] d;} txn_t;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] DM_address, DM_in, DM_out, mem_addr, mem_wdata, mem_rdata;
  logic DM_enable, DM_write, stall, mem_req, mem_we, mem_gnt, mem_rvalid;
  int n_checks = 0, n_fail = 0;
  int gnt_delay = 0, rv_delay = 0, wait_cnt = 0, rv_cnt = 0, nreads = 0, mon_n;
  bit hold_gnt = 0, stray = 0, rv_pend = 0;
  logic [31:0] rv_data;
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rd_q [$];
  txn_t tlog [$];
  wr_t exp_w [$];
  int st;
  logic [31:0] rd, ra, rdat, re;
  logic rw;

  dm_bridge dut (
    .clk(clk), .rst(rst), .DM_address(DM_address), .DM_in(DM_in), .DM_enable(DM_enable),
    .DM_write(DM_write), .DM_out(DM_out), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : ~a;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory/bus responder: grant after gnt_delay request cycles, read data rv_delay cycles later
  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_gnt = 0; mem_rvalid = 0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1; mem_rdata = rv_data; rv_pend = 0;
        end else rv_cnt--;
      end else if (mem_req && !hold_gnt) begin
        if (wait_cnt < gnt_delay) begin
          wait_cnt++;
          if (stray && !mem_we) begin mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0; end
        end else begin
          mem_gnt = 1; wait_cnt = 0;
          tlog.push_back('{mem_we, mem_addr, mem_wdata});
          if (mem_we) bus_mem[mem_addr] = mem_wdata;
          else begin
            nreads++;
            rv_data = (rd_q.size() > 0) ? rd_q.pop_front() : bus_rd(mem_addr);
            rv_pend = 1; rv_cnt = rv_delay;
          end
        end
      end
    end
  end

  task automatic cpu_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int s, output logic [31:0] r);
    @(negedge clk);
    DM_enable = 1; DM_write = w; DM_address = a; DM_in = d; s = 0;
    #1;
    while (stall && s < 300) begin s++; @(negedge clk); #1; end
    check("access_no_timeout", {63'b0, s < 300}, 64'd1);
    r = DM_out;
    if (w) begin ref_mem[a] = d; exp_w.push_back('{a, d}); end
    @(posedge clk); #1;
    DM_enable = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int q = 0, n = 0;
    while (q < 3 && n < 300) begin @(negedge clk); #1; q = mem_req ? 0 : q + 1; n++; end
    check("drain_no_timeout", {63'b0, n < 300}, 64'd1);
  endtask

  task automatic compare_writes();
    wr_t got [$];
    foreach (tlog[i]) if (tlog[i].we) got.push_back('{tlog[i].a, tlog[i].d});
    check("write_count", got.size(), exp_w.size());
    for (int i = 0; i < got.size() && i < exp_w.size(); i++) begin
      check("write_addr", got[i].a, exp_w[i].a);
      check("write_data", got[i].d, exp_w[i].d);
    end
    tlog.delete(); exp_w.delete();
  endtask

  initial begin
    rst = 0; DM_enable = 0; DM_write = 0; DM_address = 0; DM_in = 0;
    repeat (2) @(negedge clk);
    DM_enable = 1; DM_address = 32'h100;
    #1 check("stall_in_reset", stall, 0);
    DM_enable = 0;
    check("rst_dm_out", DM_out, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); #3 rst = 1;

    // minimum-latency load
    bus_mem[32'h100] = 32'hDEADBEEF;
    cpu_access(0, 32'h100, 0, st, rd);
    check("min_ld_stall", st, 3);
    check("min_ld_data", rd, 32'hDEADBEEF);
    idle(3);
    #1 check("min_ld_hold", DM_out, 32'hDEADBEEF);

    // reset while waiting for read data, then a late rvalid
    rv_delay = 5;
    @(negedge clk); DM_enable = 1; DM_write = 0; DM_address = 32'h100;
    repeat (2) @(negedge clk);
    #3 rst = 0;
    #1 check("rwait_rst_stall", stall, 0);
    check("rwait_rst_req", mem_req, 0);
    check("rwait_rst_out", DM_out, 0);
    DM_enable = 0;
    repeat (2) @(negedge clk);
    #3 rst = 1;
    repeat (6) @(negedge clk);
    #1 check("late_rv_out", DM_out, 0);
    check("late_rv_req", mem_req, 0);
    check("late_rv_stall", stall, 0);
    rv_delay = 0;
    cpu_access(0, 32'h100, 0, st, rd);
    check("post_rst_ld_stall", st, 3);
    check("post_rst_ld_data", rd, 32'hDEADBEEF);
    idle(2);

    // three stores with the bus refusing grants
    tlog.delete(); exp_w.delete();
    hold_gnt = 1;
    cpu_access(1, 32'h10, 1, st, rd);
    check("st1_stall", st, 0);
    cpu_access(1, 32'h14, 2, st, rd);
    check("st2_stall", st, 0);
    fork
      cpu_access(1, 32'h18, 3, st, rd);
      begin repeat (3) @(negedge clk); #2 hold_gnt = 0; end
    join
    check("st3_stall", st, 4);
    wait_drain();
    compare_writes();

    // store then load of the same address with slow grants
    gnt_delay = 4;
    cpu_access(1, 32'h20, 32'h55, st, rd);
    check("raw_st_stall", st, 0);
    cpu_access(0, 32'h20, 0, st, rd);
    check("raw_ld_stall", st, 13);
    check("raw_ld_data", rd, 32'h55);
    check("raw_order0", {tlog[0].we, tlog[0].a}, {1'b1, 32'h20});
    check("raw_order1", {tlog[1].we, tlog[1].a}, {1'b0, 32'h20});
    compare_writes();

    // slow grant with stray rvalid while the read request waits
    bus_mem[32'h40] = 32'h12345678;
    gnt_delay = 5; stray = 1;
    fork
      cpu_access(0, 32'h40, 0, st, rd);
      begin
        mon_n = 0;
        do begin @(negedge clk); #2; mon_n++; end while (!mem_req && mon_n < 20);
        for (int k = 0; k < 5; k++) begin
          check("rreq_hold_req", mem_req, 1);
          check("rreq_hold_we", mem_we, 0);
          check("rreq_hold_addr", mem_addr, 32'h40);
          @(negedge clk); #2;
        end
      end
    join
    stray = 0; gnt_delay = 0;
    check("stray_ld_stall", st, 8);
    check("stray_ld_data", rd, 32'h12345678);

    // back-to-back loads of one address
    nreads = 0;
    rd_q.push_back(32'hA); rd_q.push_back(32'hB);
    cpu_access(0, 32'h80, 0, st, rd);
    check("b2b_ld1_data", rd, 32'hA);
    cpu_access(0, 32'h80, 0, st, rd);
    check("b2b_ld2_data", rd, 32'hB);
    check("b2b_reads", nreads, 2);
    idle(3);
    #1 check("b2b_hold", DM_out, 32'hB);
    tlog.delete();

    // randomized mix against the CPU-view memory model
    for (int i = 0; i < 200; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
      rdat = $urandom;
      gnt_delay = $urandom_range(0, 3);
      rv_delay = $urandom_range(0, 3);
      re = exp_rd(ra);
      cpu_access(rw, ra, rdat, st, rd);
      if (!rw) begin
        check("rnd_ld_data", rd, re);
        check("rnd_ld_min_lat", {63'b0, st >= 3}, 64'd1);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    wait_drain();
    compare_writes();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_bridge.md
# dm_bridge

Sits between the CPU's data-memory port and a variable-latency, handshaked data SRAM/bus. It posts stores into a small write buffer so the pipeline runs on. It stalls the pipeline on loads until the buffer has drained and read data has returned. It drives the CPU's global `stall` input and supplies `DM_out`.

## Interface
Parameters:
- `ADDR_W`, 32: address width (byte address, word-aligned accesses only).
- `DATA_W`, 32: data width.
- `WB_DEPTH`, 2: write-buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `DM_address`  in  ADDR_W  CPU access address.
- `DM_in`  in  DATA_W  CPU store data.
- `DM_enable`  in  1  CPU access valid.
- `DM_write`  in  1  1 = store, 0 = load.
- `DM_out`  out  DATA_W  load data to CPU.
- `stall`  out  1  freezes the CPU pipeline.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  ADDR_W  request address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  DATA_W  read data.

## Operation
- The CPU holds `DM_*` stable while `stall`=1. An access is consumed on the rising edge where `DM_enable`=1 and `stall`=0.
- Store: pushed into the write-buffer FIFO on the consuming edge. `stall`=1 whenever the FIFO is full and `DM_write`=1, even if a pop happens in the same cycle.
- Write drain: whenever the FIFO is non-empty, the FSM is in IDLE/DRAIN and `mem_req`=0, the next edge loads the head into `mem_req`=1, `mem_we`=1, `mem_addr`, `mem_wdata`.
  - The request is held until `mem_gnt`. On gnt the entry is popped.
  - In the same edge, the next entry is loaded if available; otherwise `mem_req`=0.
- Load FSM (states IDLE, DRAIN, RREQ, RWAIT, RDONE):
  - IDLE: load present, FIFO empty and `mem_req`=0 → RREQ. Load present otherwise → DRAIN.
  - DRAIN: FIFO empty and `mem_req`=0 → RREQ.
  - RREQ: `mem_req`=1, `mem_we`=0, `mem_addr`=`DM_address`. On `mem_gnt` → RWAIT.
  - RWAIT: on `mem_rvalid`, capture `mem_rdata` into the read register → RDONE.
  - RDONE: one cycle → IDLE.
- `stall` (combinational) = load present and state≠RDONE, OR store-full condition. Forced to 0 while `rst`=0.
- `DM_out` = read register. It holds its value until the next load completes, so it stays valid through the CPU's MEM and WB uses.
- `mem_rvalid` outside RWAIT is ignored. Only one memory transaction is ever outstanding.
- Load-after-store ordering is guaranteed by drain-before-read; there is no store-to-load forwarding.

## Timing
- Reset values: `DM_out`=0, `stall`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, FIFO empty, FSM=IDLE.
- `mem_*` outputs are registered.
- `mem_rvalid` arrives no earlier than the cycle after `mem_gnt`.
- Minimum load latency (empty FIFO, immediate gnt/rvalid):
  - load presented at cycle 0, `stall`=1 in cycles 0–2;
  - `mem_req` in cycle 1, rvalid in cycle 2;
  - RDONE in cycle 3 with `stall`=0 and `DM_out` valid; consumed at the end of cycle 3.
- A store into a non-full FIFO costs 0 stall cycles.
- Back-to-back loads: the second load is seen in IDLE the cycle after RDONE. There is no risk of re-issuing the same load.
- Reset asserted mid-transaction clears everything asynchronously. A late `mem_gnt`/`mem_rvalid` arriving after reset is ignored.
- FIFO pointers are log2(WB_DEPTH)+1 bits and wrap modulo 2·WB_DEPTH.
  - Full = MSBs differ and low bits equal.
  - Empty = pointers equal.
  - A simultaneous push and pop while full is impossible, because a full FIFO stalls.

## Structure
- Shared package `dm_pkg`: FSM state enum `dm_state_e` and default widths.
- One sub-module, `wbuf_fifo`: a synchronous FIFO of {addr, data} with push, pop, full, empty and head outputs, parameterised by depth.
- Everything else (FSM, arbitration, read register) lives in `dm_bridge`.

## Test plan
- Reset mid-RWAIT, then `mem_rvalid` pulse → FSM IDLE, `DM_out`=0, `mem_req`=0, `stall`=0.
- Load 0x100 with an empty FIFO, gnt immediate, `mem_rdata`=0xDEADBEEF on the next cycle → `stall` high for exactly 3 cycles; `DM_out`=0xDEADBEEF from cycle 3 and held afterwards.
- Three consecutive stores (0x10←1, 0x14←2, 0x18←3), `mem_gnt` held low → no stall on the first two, `stall`=1 on the third until the first gnt. Memory then sees writes in order 1, 2, 3.
- Store 0x20←0x55 immediately followed by a load of 0x20, with gnt delayed 4 cycles → the read request is issued only after the write gnt; `stall` stays 1 throughout DRAIN; the returned data is passed unchanged.
- Load with `mem_gnt` low for 5 cycles and stray `mem_rvalid` during RREQ → `mem_req`/`mem_addr` stay stable; the stray data is not captured.
- Two back-to-back loads of the same address, returning 0xA then 0xB → two separate memory reads; `DM_out` shows 0xA, then 0xB.
